// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types and EX/MEM memory-access states
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  // Data-cache access state owned by the EX/MEM latch.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memstate_t;

endpackage

// File: rtl/exmem_latch.sv
// rtl/exmem_latch.sv - EX/MEM pipeline latch with data-cache request handshake and memory stall
//
// Purpose: holds the ALU result and control bits of one instruction, issues the
// data-cache request for loads/stores and stalls upstream until dhit.
// Build option: EXMEM_TIMEOUT_EN adds a REQ watchdog and the mem_timeout output.
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   en, flush                    capture enable / load-a-bubble from the hazard unit
//   aluout, rdat2, pc_plus_4     execute-stage data (aluout is also the address)
//   wsel, regWEN, MemtoReg,
//   dREN, dWEN, halt, JAL        execute-stage control
//   dhit, dmemload               cache response
//   dmemREN, dmemWEN, dmemaddr,
//   dmemstore                    cache request
//   mem_stall                    freeze upstream latches
//   out_*                        registered values to the MEM/WB latch
//   mem_timeout                  watchdog flag (EXMEM_TIMEOUT_EN only)
module exmem_latch
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     en,
  input  logic     flush,
  input  word_t    aluout,
  input  word_t    rdat2,
  input  word_t    pc_plus_4,
  input  regbits_t wsel,
  input  logic     regWEN,
  input  logic     MemtoReg,
  input  logic     dREN,
  input  logic     dWEN,
  input  logic     halt,
  input  logic     JAL,
  input  logic     dhit,
  input  word_t    dmemload,
  output logic     dmemREN,
  output logic     dmemWEN,
  output word_t    dmemaddr,
  output word_t    dmemstore,
  output logic     mem_stall,
  output word_t    out_aluout,
  output word_t    out_pc_plus_4,
  output word_t    out_dmemload,
  output regbits_t out_wsel,
  output logic     out_regWEN,
  output logic     out_MemtoReg,
  output logic     out_halt,
`ifdef EXMEM_TIMEOUT_EN
  output logic     out_JAL,
  output logic     mem_timeout
`else
  output logic     out_JAL
`endif
);

  memstate_t r_state;
  memstate_t w_state_next;
  logic      r_dREN;
  logic      r_dWEN;
  word_t     r_rdat2;
  word_t     r_hold;
  logic      w_in_req;
  logic      w_cap;
  logic      w_new_mem;

  always_comb begin
    w_in_req  = (r_state == REQ);
    mem_stall = w_in_req & ~dhit;
    w_cap     = en & ~mem_stall & ~out_halt;
    w_new_mem = ~flush & (dREN | dWEN);
  end

  // A capture always decides the next state from the new instruction; without
  // one, a finished access parks in DONE so the request drops while frozen.
  always_comb begin
    w_state_next = r_state;
    if (w_cap) begin
      w_state_next = w_new_mem ? REQ : IDLE;
    end else if (w_in_req && dhit) begin
      w_state_next = DONE;
    end
  end

  // Request is only driven in REQ; a load wins when both ops are latched.
  always_comb begin
    dmemREN      = w_in_req & r_dREN;
    dmemWEN      = w_in_req & r_dWEN & ~r_dREN;
    dmemaddr     = out_aluout;
    dmemstore    = r_rdat2;
    out_dmemload = w_in_req ? dmemload : r_hold;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_dREN        <= 1'b0;
      r_dWEN        <= 1'b0;
      r_rdat2       <= '0;
      r_hold        <= '0;
      out_aluout    <= '0;
      out_pc_plus_4 <= '0;
      out_wsel      <= '0;
      out_regWEN    <= 1'b0;
      out_MemtoReg  <= 1'b0;
      out_halt      <= 1'b0;
      out_JAL       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_in_req && dhit) begin
        r_hold <= dmemload;
      end
      if (w_cap) begin
        if (flush) begin
          r_dREN        <= 1'b0;
          r_dWEN        <= 1'b0;
          r_rdat2       <= '0;
          out_aluout    <= '0;
          out_pc_plus_4 <= '0;
          out_wsel      <= '0;
          out_regWEN    <= 1'b0;
          out_MemtoReg  <= 1'b0;
          out_halt      <= 1'b0;
          out_JAL       <= 1'b0;
        end else begin
          r_dREN        <= dREN;
          r_dWEN        <= dWEN;
          r_rdat2       <= rdat2;
          out_aluout    <= aluout;
          out_pc_plus_4 <= pc_plus_4;
          out_wsel      <= wsel;
          out_regWEN    <= regWEN;
          out_MemtoReg  <= MemtoReg;
          out_halt      <= halt;
          out_JAL       <= JAL;
        end
      end
    end
  end

`ifdef EXMEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_wd_cnt;
  logic [7:0] w_wd_cnt_next;
  logic       r_timeout;

  always_comb begin
    w_wd_cnt_next = r_wd_cnt;
    if (!w_in_req) begin
      w_wd_cnt_next = '0;
    end else if (!dhit && r_wd_cnt != 8'hFF) begin
      w_wd_cnt_next = r_wd_cnt + 8'd1;
    end
  end

  // Flag is sticky until reset, independent of later completion.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_cnt_next;
      if (w_in_req && !dhit && w_wd_cnt_next == TIMEOUT_LIM) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign mem_timeout = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

endmodule
